// File: rtl/sp_mem_ctrl.sv
// Single-port memory request front-end: posted writes, one outstanding read, held response.
// Optional SP_MEM_CTRL_STATS_EN adds saturating read/write acceptance counters.
module sp_mem_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_mem_wr_en,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic                  o_busy
`ifdef SP_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]           o_rd_count,
    output logic [15:0]           o_wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   acc, rd_acc, wr_acc;

    // Ready is computed outside the FSM process so acc never loops back into it.
    assign o_req_ready = (state == IDLE) || ((state == RESP) && i_rsp_ready);
    assign acc         = i_req_valid && o_req_ready;
    assign rd_acc      = acc && !i_req_we;
    assign wr_acc      = acc && i_req_we;

    assign o_mem_wr_en   = wr_acc;
    assign o_mem_rd_en   = rd_acc;
    assign o_mem_addr    = i_req_addr;
    assign o_mem_wr_data = i_req_wdata;
    assign o_busy        = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_acc) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = RESP;
            RESP:    if (i_rsp_ready) state_nxt = rd_acc ? RD_WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory read data is only trusted in RD_WAIT; any other cycle it may be X.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
        end else if (state == RD_WAIT) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= i_mem_rd_data;
        end else if ((state == RESP) && i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

`ifdef SP_MEM_CTRL_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_count <= '0;
            o_wr_count <= '0;
        end else begin
            if (rd_acc && (o_rd_count != 16'hFFFF)) o_rd_count <= o_rd_count + 16'd1;
            if (wr_acc && (o_wr_count != 16'hFFFF)) o_wr_count <= o_wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sp_mem_ctrl.sv
// Directed bench for sp_mem_ctrl: behavioural 1-cycle memory, scoreboard queue of read data.
module tb_sp_mem_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_req_valid, i_req_we, i_rsp_ready;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_req_wdata;
    logic          o_req_ready, o_rsp_valid, o_mem_wr_en, o_mem_rd_en, o_busy;
    logic [DW-1:0] o_rsp_data, o_mem_wr_data, mem_rd_data;
    logic [AW-1:0] o_mem_addr;
`ifdef SP_MEM_CTRL_STATS_EN
    logic [15:0]   o_rd_count, o_wr_count;
`endif

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    sp_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_mem_wr_en(o_mem_wr_en), .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr),
        .o_mem_wr_data(o_mem_wr_data), .i_mem_rd_data(mem_rd_data), .o_busy(o_busy)
`ifdef SP_MEM_CTRL_STATS_EN
        , .o_rd_count(o_rd_count), .o_wr_count(o_wr_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Memory drives X on its read port except the cycle after a read strobe.
    always @(posedge i_clk) begin
        if (o_mem_wr_en) mem[o_mem_addr] <= o_mem_wr_data;
        mem_rd_data <= o_mem_rd_en ? mem[o_mem_addr] : 'x;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus plus the checks expected for that cycle.
    task automatic req(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr,
                       input logic rdy, input logic rv, input logic bsy);
        @(posedge i_clk); #1;
        i_req_valid = v; i_req_we = we; i_req_addr = a; i_req_wdata = d; i_rsp_ready = rr;
        @(negedge i_clk);
        chk("req_ready", o_req_ready, rdy);
        chk("rsp_valid", o_rsp_valid, rv);
        chk("busy", o_busy, bsy);
        chk("mem_wr_en", o_mem_wr_en, v & rdy & we);
        chk("mem_rd_en", o_mem_rd_en, v & rdy & ~we);
        chk("mem_addr", o_mem_addr, a);
        if (v && rdy) begin
            if (we) ref_mem[a] = d;
            else    exp_q.push_back(ref_mem[a]);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_pending", 32'(exp_q.size()), 32'd1);
            else                   chk("rsp_data", o_rsp_data, exp_q.pop_front());
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
        i_req_wdata = '0; i_rsp_ready = 1'b1;
        #2 i_rst_n = 1'b0; i_req_valid = 1'b1;

        // reset state
        @(negedge i_clk);
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        @(posedge i_clk); #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("rst_wr_en", o_mem_wr_en, 0);
        chk("rst_rd_en", o_mem_rd_en, 0);
        #2 i_rst_n = 1'b1;

        // write then read-after-write
        req(1, 1, 8'h10, 8'hA5, 1, 1, 0, 0);
        req(1, 0, 8'h10, 8'h00, 1, 1, 0, 0);
        req(0, 0, 8'h10, 8'h00, 1, 0, 0, 1);
        req(0, 0, 8'h10, 8'h00, 1, 1, 1, 1);
        req(0, 0, 8'h10, 8'h00, 1, 1, 0, 0);

        // backpressure: blocked write must not be accepted, response held
        req(1, 0, 8'h10, 8'h00, 0, 1, 0, 0);
        req(1, 1, 8'h20, 8'h77, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            req(1, 1, 8'h20, 8'h77, 0, 0, 1, 1);
            chk("rsp_hold", o_rsp_data, 8'hA5);
        end
        req(1, 1, 8'h20, 8'h5A, 1, 1, 1, 1);
        req(1, 0, 8'h20, 8'h00, 1, 1, 0, 0);
        req(0, 0, 8'h20, 8'h00, 1, 0, 0, 1);
        req(0, 0, 8'h20, 8'h00, 1, 1, 1, 1);

        // back-to-back reads, one every two cycles
        for (int i = 0; i < 4; i++) req(1, 1, 8'(i), 8'(i * 8'h11), 1, 1, 0, 0);
        req(1, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            req(1, 0, 8'(i), 8'h00, 1, 0, 0, 1);
            req(1, 0, 8'(i), 8'h00, 1, 1, 1, 1);
        end
        req(0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
        req(0, 0, 8'h00, 8'h00, 1, 1, 1, 1);
        req(0, 0, 8'h00, 8'h00, 1, 1, 0, 0);

        // reset during RD_WAIT drops the read
        req(1, 0, 8'h10, 8'h00, 1, 1, 0, 0);
        @(posedge i_clk); #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("rdwait_busy", o_busy, 1);
        #1 i_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_rsp_valid", o_rsp_valid, 0);
        chk("midrst_busy", o_busy, 0);
        @(negedge i_clk);
        chk("midrst_hold_rsp_valid", o_rsp_valid, 0);
        #2 i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) req(0, 0, 8'h00, 8'h00, 1, 1, 0, 0);

`ifdef SP_MEM_CTRL_STATS_EN
        chk("stats_rd_zero", o_rd_count, 0);
        chk("stats_wr_zero", o_wr_count, 0);
        for (int i = 0; i < 3; i++) req(1, 1, 8'(8'h40 + i), 8'(i), 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            req(1, 0, 8'(8'h40 + i), 8'h00, 1, 1, 0, 0);
            req(0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
            req(0, 0, 8'h00, 8'h00, 1, 1, 1, 1);
        end
        req(0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        chk("stats_wr_count", o_wr_count, 3);
        chk("stats_rd_count", o_rd_count, 2);
        @(posedge i_clk); #1;
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 8'h50; i_req_wdata = 8'h00;
        ref_mem[8'h50] = 8'h00;
        repeat (65532) @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("stats_wr_max", o_wr_count, 16'hFFFF);
        req(1, 1, 8'h50, 8'h00, 1, 1, 0, 0);
        req(0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        chk("stats_wr_sat", o_wr_count, 16'hFFFF);
        chk("stats_rd_after_sat", o_rd_count, 2);
`endif

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
